// File: rtl/isp_frame_ctrl.sv
// rtl/isp_frame_ctrl.sv - frame sequencer and shadowed configuration for the ISP chain
module isp_frame_ctrl #(
    parameter int unsigned H_ACT    = 1280,
    parameter int unsigned V_ACT    = 720,
    parameter int unsigned PIPE_LAT = 16,
    parameter logic [7:0]  THR_INIT = 8'd128,
    parameter logic        VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        de_i,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [7:0]  threshold,
    output logic [10:0] roi_x,
    output logic [10:0] roi_y,
    output logic        bypass_mid,
    output logic        bypass_gauss,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        cfg_pending,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic        line_err,
    output logic [15:0] frame_cnt
);
    localparam int unsigned    DW         = $clog2(PIPE_LAT + 2);
    localparam logic [10:0]    H_LEN      = 11'(H_ACT);
    localparam logic [10:0]    V_LAST     = 11'(V_ACT - 1);
    localparam logic [10:0]    SAT        = 11'h7ff;
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(PIPE_LAT);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          vs_d1_q, vs_d2_q, de_d1_q, de_d2_q;
    logic [7:0]    thr_q, thr_d, sh_thr_q, sh_thr_d;
    logic [10:0]   roi_x_q, roi_x_d, sh_roi_x_q, sh_roi_x_d;
    logic [10:0]   roi_y_q, roi_y_d, sh_roi_y_q, sh_roi_y_d;
    logic [1:0]    mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic          pend_q, pend_d;
    logic [10:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          line_err_q, line_err_d;
    logic          done_q, done_d, ferr_q, ferr_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          vs_n, fs, le;
    logic [5:0]    unused_inputs;

    // hsync carries no information beyond de; upper write-data bits are truncated away
    assign unused_inputs = {hsync_i, cfg_wdata[15:11]};

    assign vs_n = ~(vsync_i ^ VS_POL);
    assign fs   = vs_d1_q & ~vs_d2_q;
    assign le   = ~de_d1_q & de_d2_q;

    // Next state: shadow writes, counters, line check, frame FSM; fs overrides everything
    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        roi_x_d    = roi_x_q;
        roi_y_d    = roi_y_q;
        mode_d     = mode_q;
        sh_thr_d   = sh_thr_q;
        sh_roi_x_d = sh_roi_x_q;
        sh_roi_y_d = sh_roi_y_q;
        sh_mode_d  = sh_mode_q;
        pend_d     = pend_q;
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        line_err_d = line_err_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        fcnt_d     = fcnt_q;
        cnt_d      = cnt_q;

        if (de_i && pix_x_q != SAT) pix_x_d = pix_x_q + 11'd1;
        // a new line may start in the very cycle the previous one is closed
        if (le) pix_x_d = de_i ? 11'd1 : 11'd0;

        if (state_q == ACTIVE && le) begin
            if (pix_y_q != SAT) pix_y_d = pix_y_q + 11'd1;
            if (pix_x_q != H_LEN) line_err_d = 1'b1;
            if (pix_y_q == V_LAST) begin
                state_d = DRAIN;
                cnt_d   = DRAIN_LOAD;
            end
        end

        if (state_q == DRAIN) begin
            if (cnt_q <= DW'(1)) begin
                done_d  = 1'b1;
                fcnt_d  = fcnt_q + 16'd1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - DW'(1);
            end
        end

        if (fs) begin
            thr_d      = sh_thr_q;
            roi_x_d    = sh_roi_x_q;
            roi_y_d    = sh_roi_y_q;
            mode_d     = sh_mode_q;
            pend_d     = 1'b0;
            line_err_d = 1'b0;
            pix_x_d    = 11'd0;
            pix_y_d    = 11'd0;
            state_d    = ACTIVE;
            done_d     = (state_q == DRAIN);
            ferr_d     = (state_q == ACTIVE);
            fcnt_d     = (state_q == DRAIN) ? fcnt_q + 16'd1 : fcnt_q;
        end

        // a write coinciding with fs lands in the shadow and waits for the next frame
        if (cfg_wr) begin
            pend_d = 1'b1;
            case (cfg_addr)
                2'd0:    sh_thr_d   = cfg_wdata[7:0];
                2'd1:    sh_roi_x_d = cfg_wdata[10:0];
                2'd2:    sh_roi_y_d = cfg_wdata[10:0];
                default: sh_mode_d  = cfg_wdata[1:0];
            endcase
        end
    end

    // State and input-delay registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vs_d1_q    <= 1'b0;
            vs_d2_q    <= 1'b0;
            de_d1_q    <= 1'b0;
            de_d2_q    <= 1'b0;
            thr_q      <= THR_INIT;
            roi_x_q    <= 11'd0;
            roi_y_q    <= 11'd0;
            mode_q     <= 2'd0;
            sh_thr_q   <= THR_INIT;
            sh_roi_x_q <= 11'd0;
            sh_roi_y_q <= 11'd0;
            sh_mode_q  <= 2'd0;
            pend_q     <= 1'b0;
            pix_x_q    <= 11'd0;
            pix_y_q    <= 11'd0;
            line_err_q <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            fcnt_q     <= 16'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            vs_d1_q    <= vs_n;
            vs_d2_q    <= vs_d1_q;
            de_d1_q    <= de_i;
            de_d2_q    <= de_d1_q;
            thr_q      <= thr_d;
            roi_x_q    <= roi_x_d;
            roi_y_q    <= roi_y_d;
            mode_q     <= mode_d;
            sh_thr_q   <= sh_thr_d;
            sh_roi_x_q <= sh_roi_x_d;
            sh_roi_y_q <= sh_roi_y_d;
            sh_mode_q  <= sh_mode_d;
            pend_q     <= pend_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            line_err_q <= line_err_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            fcnt_q     <= fcnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign threshold    = thr_q;
    assign roi_x        = roi_x_q;
    assign roi_y        = roi_y_q;
    assign bypass_mid   = mode_q[0];
    assign bypass_gauss = mode_q[1];
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign cfg_pending  = pend_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;
    assign frame_err    = ferr_q;
    assign line_err     = line_err_q;
    assign frame_cnt    = fcnt_q;
endmodule

// File: tb/tb_isp_frame_ctrl.sv
// tb/tb_isp_frame_ctrl.sv - directed self-checking bench for isp_frame_ctrl
module tb_isp_frame_ctrl;
    localparam int H = 8;
    localparam int V = 4;
    localparam int PL = 5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        hsync_i = 1'b1, vsync_i = 1'b0, de_i = 1'b0, cfg_wr = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = 16'd0;
    logic [7:0]  threshold;
    logic [10:0] roi_x, roi_y, pix_x, pix_y;
    logic        bypass_mid, bypass_gauss, cfg_pending, busy, frame_done, frame_err, line_err;
    logic [15:0] frame_cnt;

    int checks = 0, errors = 0, done_seen = 0, err_seen = 0;

    isp_frame_ctrl #(.H_ACT(H), .V_ACT(V), .PIPE_LAT(PL), .THR_INIT(8'd128), .VS_POL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .threshold(threshold), .roi_x(roi_x), .roi_y(roi_y),
        .bypass_mid(bypass_mid), .bypass_gauss(bypass_gauss),
        .pix_x(pix_x), .pix_y(pix_y), .cfg_pending(cfg_pending), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err), .line_err(line_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // one cycle: sample pulses from the previous edge, then drive new inputs
    task automatic tick(input logic v, input logic d);
        @(negedge clk);
        done_seen += int'(frame_done);
        err_seen  += int'(frame_err);
        vsync_i = v; de_i = d; hsync_i = ~d; cfg_wr = 1'b0;
    endtask

    task automatic tick_wr(input logic v, input logic d, input logic [1:0] a, input logic [15:0] w);
        tick(v, d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = w;
    endtask

    task automatic send_vs();
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic send_line(input int row, input int n, inout int bad);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1);
            if (pix_x !== 11'(i) || pix_y !== 11'(row)) bad++;
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    endtask

    task automatic lines(input int first, input int last, inout int bad);
        for (int r = first; r <= last; r++) send_line(r, H, bad);
    endtask

    task automatic run_drain(output int done_at, output logic b4, output logic b5);
        done_at = -1; b4 = 1'b0; b5 = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick(1'b0, 1'b0);
            if (frame_done === 1'b1 && done_at < 0) done_at = j;
            if (j == 4) b4 = busy;
            if (j == 5) b5 = busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        checks++;
        if ({threshold, roi_x, roi_y, bypass_mid, bypass_gauss} !== {8'h80, 11'd0, 11'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_cfg: got thr=%0h rx=%0h ry=%0h bm=%0b bg=%0b expected 80 0 0 0 0",
                     threshold, roi_x, roi_y, bypass_mid, bypass_gauss);
        end
        checks++;
        if ({pix_x, pix_y, frame_cnt} !== {11'd0, 11'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_counts: got px=%0d py=%0d fc=%0d expected 0 0 0", pix_x, pix_y, frame_cnt);
        end
        checks++;
        if ({cfg_pending, busy, frame_done, frame_err, line_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {cfg_pending, busy, frame_done, frame_err, line_err});
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic test_nominal();
        int bad = 0, d; logic b4, b5;
        done_seen = 0; err_seen = 0;
        send_vs();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_start: got %b expected 1", busy); end
        lines(0, V - 1, bad);
        checks++;
        if (pix_y !== 11'd4) begin errors++; $display("FAIL nom_pix_y_end: got %0d expected 4", pix_y); end
        run_drain(d, b4, b5);
        checks++;
        if (d !== PL) begin errors++; $display("FAIL nom_done_latency: got %0d expected %0d", d, PL); end
        checks++;
        if ({b4, b5} !== 2'b10) begin errors++; $display("FAIL nom_busy_drop: got %b expected 10", {b4, b5}); end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL nom_cnt1: got %0d expected 1", frame_cnt); end
        send_vs();
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (frame_cnt !== 16'd2 || d !== PL) begin
            errors++; $display("FAIL nom_cnt2: got cnt=%0d lat=%0d expected 2 %0d", frame_cnt, d, PL);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL nom_pix_coords: got %0d bad pixels expected 0", bad); end
        checks++;
        if ({line_err, err_seen, done_seen} !== {1'b0, 32'd0, 32'd2}) begin
            errors++;
            $display("FAIL nom_flags: got le=%b errs=%0d dones=%0d expected 0 0 2", line_err, err_seen, done_seen);
        end
    endtask

    task automatic test_mid_cfg();
        int bad = 0, d; logic b4, b5;
        send_vs();
        lines(0, 0, bad);
        tick_wr(1'b0, 1'b0, 2'd0, 16'h0040);
        tick_wr(1'b0, 1'b0, 2'd1, 16'hffff);
        tick_wr(1'b0, 1'b0, 2'd2, 16'h0123);
        tick(1'b0, 1'b0);
        checks++;
        if ({threshold, roi_x, cfg_pending} !== {8'h80, 11'd0, 1'b1}) begin
            errors++; $display("FAIL cfg_hold: got thr=%0h rx=%0h pend=%b expected 80 0 1", threshold, roi_x, cfg_pending);
        end
        lines(1, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (threshold !== 8'h80 || frame_cnt !== 16'd3) begin
            errors++; $display("FAIL cfg_frame_end: got thr=%0h cnt=%0d expected 80 3", threshold, frame_cnt);
        end
        send_vs();
        checks++;
        if ({threshold, cfg_pending} !== {8'h40, 1'b0}) begin
            errors++; $display("FAIL cfg_commit: got thr=%0h pend=%b expected 40 0", threshold, cfg_pending);
        end
        checks++;
        if ({roi_x, roi_y} !== {11'h7ff, 11'h123}) begin
            errors++; $display("FAIL cfg_roi_trunc: got rx=%0h ry=%0h expected 7ff 123", roi_x, roi_y);
        end
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (bad !== 0 || frame_cnt !== 16'd4) begin
            errors++; $display("FAIL cfg_frames: got bad=%0d cnt=%0d expected 0 4", bad, frame_cnt);
        end
    endtask

    task automatic test_fs_write();
        int bad = 0, d; logic b4, b5;
        tick(1'b1, 1'b0);
        tick_wr(1'b1, 1'b0, 2'd3, 16'h0003);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        checks++;
        if ({bypass_mid, bypass_gauss, cfg_pending, busy} !== 4'b0011) begin
            errors++; $display("FAIL fsw_same_frame: got bm=%b bg=%b pend=%b busy=%b expected 0 0 1 1",
                               bypass_mid, bypass_gauss, cfg_pending, busy);
        end
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        send_vs();
        checks++;
        if ({bypass_mid, bypass_gauss, cfg_pending, threshold} !== {3'b110, 8'h40}) begin
            errors++; $display("FAIL fsw_next_frame: got bm=%b bg=%b pend=%b thr=%0h expected 1 1 0 40",
                               bypass_mid, bypass_gauss, cfg_pending, threshold);
        end
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (frame_cnt !== 16'd6) begin errors++; $display("FAIL fsw_cnt: got %0d expected 6", frame_cnt); end
    endtask

    task automatic test_short_frame();
        int bad = 0, d; logic b4, b5;
        send_vs();
        lines(0, 1, bad);
        done_seen = 0; err_seen = 0;
        send_vs();
        checks++;
        if (err_seen !== 1 || done_seen !== 0) begin
            errors++; $display("FAIL short_pulses: got errs=%0d dones=%0d expected 1 0", err_seen, done_seen);
        end
        checks++;
        if ({frame_cnt, pix_y, busy} !== {16'd6, 11'd0, 1'b1}) begin
            errors++; $display("FAIL short_state: got cnt=%0d py=%0d busy=%b expected 6 0 1", frame_cnt, pix_y, busy);
        end
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (frame_cnt !== 16'd7 || d !== PL || err_seen !== 1) begin
            errors++; $display("FAIL short_recover: got cnt=%0d lat=%0d errs=%0d expected 7 %0d 1", frame_cnt, d, err_seen, PL);
        end
    endtask

    task automatic test_bad_line();
        int bad = 0, d; logic b4, b5;
        send_vs();
        send_line(0, H, bad);
        checks++;
        if (line_err !== 1'b0) begin errors++; $display("FAIL badl_clean: got %b expected 0", line_err); end
        send_line(1, H - 1, bad);
        checks++;
        if (line_err !== 1'b1) begin errors++; $display("FAIL badl_set: got %b expected 1", line_err); end
        lines(2, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if ({line_err, frame_cnt} !== {1'b1, 16'd8} || d !== PL) begin
            errors++; $display("FAIL badl_frame_end: got le=%b cnt=%0d lat=%0d expected 1 8 %0d", line_err, frame_cnt, d, PL);
        end
        send_vs();
        checks++;
        if (line_err !== 1'b0) begin errors++; $display("FAIL badl_clear: got %b expected 0", line_err); end
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (bad !== 0 || frame_cnt !== 16'd9) begin
            errors++; $display("FAIL badl_after: got bad=%0d cnt=%0d expected 0 9", bad, frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0, d; logic b4, b5;
        send_vs();
        lines(0, V - 1, bad);
        done_seen = 0; err_seen = 0;
        send_vs();
        checks++;
        if (done_seen !== 1 || err_seen !== 0) begin
            errors++; $display("FAIL b2b_pulses: got dones=%0d errs=%0d expected 1 0", done_seen, err_seen);
        end
        checks++;
        if ({frame_cnt, busy, pix_y} !== {16'd10, 1'b1, 11'd0}) begin
            errors++; $display("FAIL b2b_state: got cnt=%0d busy=%b py=%0d expected 10 1 0", frame_cnt, busy, pix_y);
        end
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (frame_cnt !== 16'd11 || d !== PL || done_seen !== 2 || bad !== 0) begin
            errors++; $display("FAIL b2b_next: got cnt=%0d lat=%0d dones=%0d bad=%0d expected 11 %0d 2 0",
                               frame_cnt, d, done_seen, bad, PL);
        end
    endtask

    task automatic test_reset_drain();
        int bad = 0, d; logic b4, b5;
        send_vs();
        lines(0, 0, bad);
        tick_wr(1'b0, 1'b0, 2'd0, 16'h0022);
        tick_wr(1'b0, 1'b0, 2'd3, 16'h0002);
        lines(1, V - 1, bad);
        tick(1'b0, 1'b0);
        checks++;
        if ({busy, cfg_pending} !== 2'b11) begin
            errors++; $display("FAIL rstd_pre: got busy=%b pend=%b expected 1 1", busy, cfg_pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({threshold, frame_cnt, busy, cfg_pending, bypass_mid, bypass_gauss, pix_y} !==
            {8'h80, 16'd0, 4'b0000, 11'd0}) begin
            errors++; $display("FAIL rstd_values: got thr=%0h cnt=%0d busy=%b pend=%b bm=%b bg=%b py=%0d expected 80 0 0 0 0 0 0",
                               threshold, frame_cnt, busy, cfg_pending, bypass_mid, bypass_gauss, pix_y);
        end
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        send_vs();
        checks++;
        if ({threshold, bypass_mid, bypass_gauss, cfg_pending, busy} !== {8'h80, 4'b0001}) begin
            errors++; $display("FAIL rstd_defaults: got thr=%0h bm=%b bg=%b pend=%b busy=%b expected 80 0 0 0 1",
                               threshold, bypass_mid, bypass_gauss, cfg_pending, busy);
        end
        lines(0, V - 1, bad);
        run_drain(d, b4, b5);
        checks++;
        if (frame_cnt !== 16'd1 || d !== PL) begin
            errors++; $display("FAIL rstd_frame: got cnt=%0d lat=%0d expected 1 %0d", frame_cnt, d, PL);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mid_cfg();
        test_fs_write();
        test_short_frame();
        test_bad_line();
        test_back_to_back();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/isp_frame_ctrl.md
Name: isp_frame_ctrl

Overview:
Frame-level sequencer and configuration manager for the YCbCr → median → Gauss ISP chain.
- Tracks the incoming video timing and generates per-pixel coordinates.
- Holds the threshold, ROI and stage-bypass settings in shadow registers and commits them only at frame start, so the parameters never change mid-frame.
- Checks frame geometry and signals frame completion once the pipeline has drained.

Parameters:
H_ACT, 1280, active pixels per line (de-high cycles per line)
V_ACT, 720, active lines per frame
PIPE_LAT, 16, pipeline drain cycles after the last active pixel
THR_INIT, 8'd128, reset value of threshold
VS_POL, 1'b1, vsync active level (1 = active-high)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hsync_i  in  1  line sync from the video source
vsync_i  in  1  frame sync from the video source
de_i  in  1  data enable from the video source
cfg_wr  in  1  config write strobe, one cycle per write
cfg_addr  in  2  0=threshold, 1=roi_x, 2=roi_y, 3=mode
cfg_wdata  in  16  write data, LSB-aligned
threshold  out  8  active threshold
roi_x  out  11  active ROI x
roi_y  out  11  active ROI y
bypass_mid  out  1  mode[0]: median stage bypass
bypass_gauss  out  1  mode[1]: Gauss stage bypass
pix_x  out  11  column index of the current de_i pixel
pix_y  out  11  row index of the current de_i pixel
cfg_pending  out  1  shadow holds uncommitted writes
busy  out  1  state is ACTIVE or DRAIN
frame_done  out  1  one-cycle pulse at frame completion
frame_err  out  1  one-cycle pulse on a short frame
line_err  out  1  sticky: a line length ≠ H_ACT in the current frame
frame_cnt  out  16  completed-frame counter

Behaviour:
- Single clock domain. Async active-low reset. All state is registered.
- Reset values: threshold=THR_INIT; roi_x=0; roi_y=0; mode=0; all shadow registers equal the active registers; pix_x=0; pix_y=0; all flags 0; frame_cnt=0; state=IDLE.
- Input registering:
  - vs_n = vsync_i XNOR VS_POL.
  - vs_n and de_i are each delayed one cycle.
  - fs (frame start) = rising edge of vs_n; le (line end) = falling edge of de_i. Both are detected one cycle after the input edge.
- Config writes:
  - cfg_wr writes cfg_wdata, truncated to the target width, into the shadow register at cfg_addr and sets cfg_pending.
  - Writes are accepted in every state. Outputs never change on a write.
- Commit on fs, in any state: active ← shadow, cfg_pending ← 0, line_err ← 0, pix_x ← 0, pix_y ← 0.
  - A cfg_wr in the same cycle as fs updates the shadow only; cfg_pending stays 1 and that write applies at the next fs.
- Counters:
  - pix_x increments on each de_i cycle. It resets to 0 on le and on fs.
  - pix_y increments on le. It resets on fs.
  - Both saturate at 2047.
- Line check: on le, if the count of de cycles in that line ≠ H_ACT, set line_err. It stays set until the next fs.
- FSM:
  - IDLE: on fs → ACTIVE.
  - ACTIVE: on an le that completes line V_ACT−1 → DRAIN, loading the drain counter with PIPE_LAT. On fs before the last line: pulse frame_err, commit, stay in ACTIVE (new frame); frame_cnt does not change.
  - DRAIN: the counter decrements each cycle. At 0: pulse frame_done, frame_cnt += 1 (wraps at 16 bits), → IDLE.
  - fs during DRAIN: abort the drain, pulse frame_done, increment frame_cnt, commit, → ACTIVE, all in the same cycle.
- de_i in IDLE or DRAIN is ignored for row tracking and state; pix_x still counts.
- busy = (state != IDLE).
- frame_done and frame_err are never asserted in the same cycle.
- Reset mid-frame: everything returns to reset values; pending shadow writes are lost. The block waits in IDLE for the next fs.

Test Plan:
1. Nominal frames (H_ACT=8, V_ACT=4, PIPE_LAT=5), two frames of 4×8 de → pix_x runs 0..7 and pix_y 0..3 on the de cycles; frame_done pulses 5 cycles after the internal le of line 3; frame_cnt=1 then 2; busy drops after frame_done; line_err=0.
2. Mid-frame config: write threshold=0x40 during line 1 → threshold stays 0x80 for the rest of the frame and cfg_pending=1; at the next fs threshold=0x40 and cfg_pending=0.
3. Write on the fs cycle: cfg_wr addr 3 data 0x3 in the exact fs cycle → bypass bits stay 0 for that frame with cfg_pending=1; at the following fs both bypass bits = 1.
4. Short frame: fs after only 2 lines → frame_err pulses once, frame_cnt is unchanged, pix_y returns to 0, state stays ACTIVE.
5. Bad line length: one line of 7 de cycles → line_err=1 until the next fs, then 0; frame_done still pulses normally.
6. Reset during DRAIN with cfg_pending=1 → all outputs return to reset values (threshold=0x80, frame_cnt=0); the next fs starts a frame with the defaults.
